// File: rtl/sonar_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// sonar_pkg: shared state encoding, default timing constants and helpers.
// Rev 1.0
// ---------------------------------------------------------------------------
package sonar_pkg;

  localparam int unsigned DEF_TRIG_CYCLES  = 650;
  localparam int unsigned DEF_SLOT_CYCLES  = 1625000;
  localparam int unsigned DEF_RISE_TIMEOUT = 65000;
  localparam int unsigned DEF_CYC_PER_UNIT = 956;
  localparam int unsigned DEF_MAX_JUMP     = 20;
  localparam int unsigned RAW_MAX          = 511;
  localparam int unsigned RAW_W            = 9;
  localparam int unsigned MIN_CNT_W        = 21;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    TRIG      = 3'd1,
    WAIT_RISE = 3'd2,
    MEASURE   = 3'd3,
    FILTER    = 3'd4,
    GAP       = 3'd5
  } state_e;

  function automatic int unsigned cnt_width(input int unsigned max_count);
    int unsigned w;
    w = $clog2(max_count + 1);
    return (w > MIN_CNT_W) ? w : MIN_CNT_W;
  endfunction

endpackage
`default_nettype wire

// File: rtl/sonar_filter.sv
`default_nettype none
// ---------------------------------------------------------------------------
// sonar_filter: per-channel jump filter holding prev_raw and the distance.
// Rev 1.0
// ---------------------------------------------------------------------------
module sonar_filter
  import sonar_pkg::*;
#(
  parameter int unsigned MAX_JUMP = DEF_MAX_JUMP
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             sample_i,
  input  logic [RAW_W-1:0] raw_i,
  output logic [RAW_W-1:0] dist_o,
  output logic             valid_o
);

  localparam int unsigned    JUMP_CLAMP = (MAX_JUMP > RAW_MAX) ? RAW_MAX : MAX_JUMP;
  localparam logic [RAW_W:0] JUMP_LIM   = JUMP_CLAMP[RAW_W:0];

  logic [RAW_W-1:0]        prev_raw_q;
  logic [RAW_W-1:0]        dist_q;
  logic                    valid_q;
  logic signed [RAW_W:0]   diff_w;
  logic [RAW_W:0]          mag_w;
  logic                    accept_w;

  // One extra sign bit keeps the difference exact over the full 0..511 range.
  always_comb begin
    diff_w   = $signed({1'b0, raw_i}) - $signed({1'b0, prev_raw_q});
    mag_w    = diff_w[RAW_W] ? -diff_w : diff_w;
    accept_w = (mag_w <= JUMP_LIM);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      prev_raw_q <= '0;
      dist_q     <= '0;
      valid_q    <= 1'b0;
    end else begin
      valid_q <= sample_i && accept_w;
      if (sample_i) begin
        prev_raw_q <= raw_i;
        if (accept_w) begin
          dist_q <= raw_i;
        end
      end
    end
  end

  assign dist_o  = dist_q;
  assign valid_o = valid_q;

endmodule
`default_nettype wire

// File: rtl/sonar_scheduler.sv
`default_nettype none
// ---------------------------------------------------------------------------
// sonar_scheduler: alternating two-sensor ultrasonic trigger/echo ranging.
// Rev 1.0
// ---------------------------------------------------------------------------
module sonar_scheduler
  import sonar_pkg::*;
#(
  parameter int unsigned TRIG_CYCLES  = DEF_TRIG_CYCLES,
  parameter int unsigned SLOT_CYCLES  = DEF_SLOT_CYCLES,
  parameter int unsigned RISE_TIMEOUT = DEF_RISE_TIMEOUT,
  parameter int unsigned CYC_PER_UNIT = DEF_CYC_PER_UNIT,
  parameter int unsigned MAX_JUMP     = DEF_MAX_JUMP
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [1:0]       echo,
  output logic [1:0]       trig,
  output logic [RAW_W-1:0] dist0,
  output logic [RAW_W-1:0] dist1,
  output logic [1:0]       dist_valid,
  output logic [1:0]       timeout_err
);

  localparam int unsigned      CNT_W     = cnt_width(SLOT_CYCLES);
  localparam logic [CNT_W-1:0] TRIG_LAST = CNT_W'(TRIG_CYCLES - 1);
  localparam logic [CNT_W-1:0] SLOT_LAST = CNT_W'(SLOT_CYCLES - 1);
  localparam logic [CNT_W-1:0] RISE_LAST = CNT_W'(RISE_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] UNIT_LAST = CNT_W'(CYC_PER_UNIT - 1);
  localparam logic [RAW_W-1:0] UNIT_PRE  = RAW_W'(RAW_MAX - 1);

  state_e           state_q, state_d;
  logic             ch_q, ch_d;
  logic [CNT_W-1:0] slot_cnt_q, slot_cnt_d;
  logic [CNT_W-1:0] cyc_cnt_q, cyc_cnt_d;
  logic [RAW_W-1:0] unit_q, unit_d;
  logic [1:0]       timeout_q, timeout_d;
  logic [1:0]       echo_meta_q, echo_sync_q, echo_dly_q;
  logic             rise_w, meas_w;
  logic [1:0]       sample_w;
  logic [RAW_W-1:0] dist_w [2];

  // The delayed copy gives both the rise detector and an aligned count of every high cycle.
  assign rise_w = echo_sync_q[ch_q] & ~echo_dly_q[ch_q];
  assign meas_w = echo_dly_q[ch_q];

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      ch_q        <= 1'b0;
      slot_cnt_q  <= '0;
      cyc_cnt_q   <= '0;
      unit_q      <= '0;
      timeout_q   <= '0;
      echo_meta_q <= '0;
      echo_sync_q <= '0;
      echo_dly_q  <= '0;
    end else begin
      state_q     <= state_d;
      ch_q        <= ch_d;
      slot_cnt_q  <= slot_cnt_d;
      cyc_cnt_q   <= cyc_cnt_d;
      unit_q      <= unit_d;
      timeout_q   <= timeout_d;
      echo_meta_q <= echo;
      echo_sync_q <= echo_meta_q;
      echo_dly_q  <= echo_sync_q;
    end
  end

  always_comb begin
    state_d    = state_q;
    ch_d       = ch_q;
    slot_cnt_d = slot_cnt_q + 1'b1;
    cyc_cnt_d  = cyc_cnt_q;
    unit_d     = unit_q;
    timeout_d  = 2'b00;
    unique case (state_q)
      IDLE: begin
        slot_cnt_d = '0;
        if (en) begin
          state_d = TRIG;
        end
      end
      TRIG: begin
        if (slot_cnt_q == TRIG_LAST) begin
          state_d   = WAIT_RISE;
          cyc_cnt_d = '0;
        end
      end
      WAIT_RISE: begin
        if (rise_w) begin
          state_d   = MEASURE;
          cyc_cnt_d = '0;
          unit_d    = '0;
        end else if (cyc_cnt_q == RISE_LAST) begin
          state_d         = GAP;
          timeout_d[ch_q] = 1'b1;
        end else begin
          cyc_cnt_d = cyc_cnt_q + 1'b1;
        end
      end
      MEASURE: begin
        if (!meas_w) begin
          state_d = FILTER;
        end else if (cyc_cnt_q == UNIT_LAST) begin
          cyc_cnt_d = '0;
          unit_d    = unit_q + 1'b1;
          if (unit_q == UNIT_PRE) begin
            state_d = FILTER;
          end
        end else begin
          cyc_cnt_d = cyc_cnt_q + 1'b1;
        end
      end
      FILTER: begin
        state_d = GAP;
      end
      GAP: begin
        if (slot_cnt_q >= SLOT_LAST) begin
          slot_cnt_d = '0;
          ch_d       = ~ch_q;
          state_d    = en ? TRIG : IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_comb begin
    trig     = 2'b00;
    sample_w = 2'b00;
    if (state_q == TRIG) begin
      trig[ch_q] = 1'b1;
    end
    if (state_q == FILTER) begin
      sample_w[ch_q] = 1'b1;
    end
  end

  for (genvar gi = 0; gi < 2; gi++) begin : g_chan
    sonar_filter #(
      .MAX_JUMP (MAX_JUMP)
    ) u_filter (
      .clk      (clk),
      .rst      (rst),
      .sample_i (sample_w[gi]),
      .raw_i    (unit_q),
      .dist_o   (dist_w[gi]),
      .valid_o  (dist_valid[gi])
    );
  end

  assign dist0       = dist_w[0];
  assign dist1       = dist_w[1];
  assign timeout_err = timeout_q;

endmodule
`default_nettype wire

// File: tb/tb_sonar_scheduler.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_sonar_scheduler: directed and randomized slots against a slot-level model.
// Rev 1.0
// ---------------------------------------------------------------------------
module tb_sonar_scheduler;

  localparam int TRIG = 4;
  localparam int SLOT = 1200;
  localparam int RT   = 60;
  localparam int CPU  = 2;
  localparam int MJ   = 20;
  localparam int SAT  = 511;

  logic       clk;
  logic       rst;
  logic       en;
  logic [1:0] echo;
  logic [1:0] trig;
  logic [8:0] dist0;
  logic [8:0] dist1;
  logic [1:0] dist_valid;
  logic [1:0] timeout_err;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc   = 0;
  int prev_m [2];
  int dist_m [2];
  int last_start;

  sonar_scheduler #(
    .TRIG_CYCLES  (TRIG),
    .SLOT_CYCLES  (SLOT),
    .RISE_TIMEOUT (RT),
    .CYC_PER_UNIT (CPU),
    .MAX_JUMP     (MJ)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .en          (en),
    .echo        (echo),
    .trig        (trig),
    .dist0       (dist0),
    .dist1       (dist1),
    .dist_valid  (dist_valid),
    .timeout_err (timeout_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input int obs, input int exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    prev_m[0] = 0; prev_m[1] = 0;
    dist_m[0] = 0; dist_m[1] = 0;
    last_start = -1;
  endtask

  // One full slot: wait for the trigger, drive the echo (d<0 means none), score the result.
  task automatic run_slot(input int ch, input int d, input int h, input bit pre_high,
                          input int rst_at, input int en_off_at, input bit noise);
    int n, tlen, bad_trig, stray, dv_n, dv_k, dv_val, to_n, to_k, raw, diff;
    bit acc, exp_to;
    logic [1:0] exp_oh;
    n = 0; tlen = 0; bad_trig = 0; stray = 0; dv_n = 0; dv_k = -1; dv_val = -1;
    to_n = 0; to_k = -1; raw = 0;
    if (pre_high) echo[ch] = 1'b1;
    do begin
      @(negedge clk);
      n++;
    end while (trig == 2'b00 && n < SLOT + 20);
    exp_oh = 2'b00;
    exp_oh[ch] = 1'b1;
    chk("trig_onehot", int'(trig), int'(exp_oh));
    if (last_start >= 0) chk("trig_period", cyc - last_start, SLOT);
    last_start = cyc;
    while (trig[ch] && tlen < TRIG + 10) begin
      if (trig[1-ch]) bad_trig++;
      tlen++;
      @(negedge clk);
    end
    chk("trig_len", tlen, TRIG);
    for (int k = 0; k < SLOT - TRIG; k++) begin
      if (k > 0) @(negedge clk);
      if (trig != 2'b00) bad_trig++;
      if (dist_valid[ch]) begin
        dv_n++;
        dv_k = k;
        dv_val = (ch == 1) ? int'(dist1) : int'(dist0);
      end
      if (timeout_err[ch]) begin
        to_n++;
        to_k = k;
      end
      if (dist_valid[1-ch] || timeout_err[1-ch]) stray++;
      if (k == rst_at) begin
        rst = 1'b1;
        echo = 2'b00;
        @(negedge clk);
        @(negedge clk);
        chk("rst_trig", int'(trig), 0);
        chk("rst_dist0", int'(dist0), 0);
        chk("rst_dist1", int'(dist1), 0);
        chk("rst_flags", int'({dist_valid, timeout_err}), 0);
        rst = 1'b0;
        model_reset();
        return;
      end
      if (k == en_off_at) en = 1'b0;
      echo[ch]   = (d >= 0 && k >= d && k < d + h);
      echo[1-ch] = (noise && k < SLOT - TRIG - 8) ? 1'($urandom_range(0, 1)) : 1'b0;
    end
    exp_to = (d < 0 || h <= 0);
    acc = 1'b0;
    if (!exp_to) begin
      raw = h / CPU;
      if (raw > SAT) raw = SAT;
      diff = raw - prev_m[ch];
      acc = (diff <= MJ && diff >= -MJ);
      prev_m[ch] = raw;
      if (acc) dist_m[ch] = raw;
    end
    chk("trig_outside", bad_trig, 0);
    chk("other_ch_pulse", stray, 0);
    chk("dv_count", dv_n, int'(acc));
    chk("timeout_count", to_n, int'(exp_to));
    chk("dist0", int'(dist0), dist_m[0]);
    chk("dist1", int'(dist1), dist_m[1]);
    if (exp_to) chk("timeout_lat", to_k, RT);
    if (acc) chk("dv_value", dv_val, raw);
    if (acc && h >= SAT * CPU) chk("sat_exit", dv_k - d, SAT * CPU + 4);
  endtask

  initial begin
    int hi, rt_raw, dly, quiet;
    rst = 1'b1; en = 1'b0; echo = 2'b00;
    model_reset();
    repeat (3) @(negedge clk);
    chk("reset_trig", int'(trig), 0);
    chk("reset_dist0", int'(dist0), 0);
    chk("reset_dist1", int'(dist1), 0);
    chk("reset_flags", int'({dist_valid, timeout_err}), 0);
    rst = 1'b0;
    quiet = 0;
    repeat (20) begin
      @(negedge clk);
      if (trig != 2'b00) quiet++;
    end
    chk("idle_no_trig", quiet, 0);
    en = 1'b1;

    run_slot(0, 20, 200, 0, -1, -1, 0);    // raw 100
    run_slot(1, 15, 20, 0, -1, -1, 1);     // raw 10
    run_slot(0, 10, 300, 0, -1, -1, 1);    // raw 150 rejected
    run_slot(1, -1, 0, 0, -1, -1, 1);      // timeout
    run_slot(0, 5, 300, 0, -1, -1, 0);     // raw 150 accepted
    run_slot(1, 10, SAT * CPU + 50, 0, -1, -1, 0);
    run_slot(0, 10, 600, 0, -1, -1, 0);
    run_slot(1, 10, SAT * CPU + 50, 0, -1, -1, 0);
    run_slot(0, 10, 620, 1, -1, -1, 0);    // echo held through trigger

    for (int i = 0; i < 20; i++) begin
      int c;
      c = (i % 2 == 0) ? 1 : 0;
      rt_raw = prev_m[c] + int'($urandom_range(0, 60)) - 30;
      if (rt_raw < 0) rt_raw = 0;
      if (rt_raw > SAT) rt_raw = SAT;
      hi = rt_raw * CPU + int'($urandom_range(0, CPU - 1));
      if (hi == 0) hi = 1;
      dly = ($urandom_range(0, 7) == 0) ? -1 : int'($urandom_range(0, 50));
      run_slot(c, dly, hi, 0, -1, -1, 1);
    end

    run_slot(1, 10, 400, 0, 60, -1, 1);    // reset mid-measurement
    run_slot(0, 10, 20, 0, -1, -1, 0);     // restarts on channel 0
    run_slot(1, 10, 30, 0, -1, 2, 0);      // en dropped early, slot completes
    quiet = 0;
    repeat (SLOT + 100) begin
      @(negedge clk);
      if (trig != 2'b00) quiet++;
    end
    chk("en_off_idle", quiet, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
